// File: rtl/td4x_core.sv
// td4x_core: parametrised single-issue accumulator CPU (A, B, carry, PC, optional link register).
// Latency: one instruction retires per cycle; out_data/out_valid are registered and appear one cycle after OUT.
// Backpressure: an IN waits in STALL, holding all state, until in_valid is high (in_ready marks the IN).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr_addr          current PC, addresses the external combinational program memory
//   instr_data          {opcode[3:0], imm[DATA_W-1:0]} for the instruction at instr_addr
//   in_data/in_valid    input port; in_ready is high while an IN is waiting for it
//   out_data/out_valid  registered output port with a one-cycle strobe per OUT
//   halted              high once a HALT has retired, cleared only by rst
// Optional feature: define TD4X_CALL_EN to add the link register and the CALL (1100) / RET (1101)
// opcodes; without it those opcodes are NOPs.

module td4x_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W+3:0] instr_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } src_t;

    // Architectural state
    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [DATA_W-1:0] a_q,        a_d;
    logic [DATA_W-1:0] b_q,        b_d;
    logic              c_q,        c_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_vld_q,  out_vld_d;
`ifdef TD4X_CALL_EN
    logic [ADDR_W-1:0] lr_q,       lr_d;
`endif

    // Instruction fields
    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    assign opcode = instr_data[DATA_W+3:DATA_W];
    assign imm    = instr_data[DATA_W-1:0];

    // Decode
    src_t src_sel;
    logic wr_a, wr_b, wr_out;
    logic is_in, is_halt, is_jmp, is_jnc, is_call, is_ret;

    always_comb begin
        src_sel = SRC_ZERO;
        wr_a    = 1'b0;
        wr_b    = 1'b0;
        wr_out  = 1'b0;
        is_in   = 1'b0;
        is_halt = 1'b0;
        is_jmp  = 1'b0;
        is_jnc  = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        case (opcode)
            4'b0000: begin src_sel = SRC_A;    wr_a = 1'b1; end
            4'b0101: begin src_sel = SRC_B;    wr_b = 1'b1; end
            4'b0011: begin src_sel = SRC_ZERO; wr_a = 1'b1; end
            4'b0111: begin src_sel = SRC_ZERO; wr_b = 1'b1; end
            4'b0001: begin src_sel = SRC_B;    wr_a = 1'b1; end
            4'b0100: begin src_sel = SRC_A;    wr_b = 1'b1; end
            4'b0010: begin src_sel = SRC_IN;   wr_a = 1'b1; is_in = 1'b1; end
            4'b0110: begin src_sel = SRC_IN;   wr_b = 1'b1; is_in = 1'b1; end
            4'b1001: begin src_sel = SRC_B;    wr_out = 1'b1; end
            4'b1011: begin src_sel = SRC_ZERO; wr_out = 1'b1; end
            4'b1111: is_jmp  = 1'b1;
            4'b1110: is_jnc  = 1'b1;
            4'b1010: is_halt = 1'b1;
`ifdef TD4X_CALL_EN
            4'b1100: is_call = 1'b1;
            4'b1101: is_ret  = 1'b1;
`endif
            default: ; // NOP: src = 0 so the adder's carry-out is 0 and C clears on retire
        endcase
    end

    // ALU: every instruction runs src + imm; carry-out lands in C on retire
    logic [DATA_W-1:0] src_val;
    logic [DATA_W:0]   sum;

    always_comb begin
        src_val = '0;
        case (src_sel)
            SRC_A:   src_val = a_q;
            SRC_B:   src_val = b_q;
            SRC_IN:  src_val = in_data;
            default: src_val = '0;
        endcase
        sum = {1'b0, src_val} + {1'b0, imm};
    end

    logic              active;
    logic              stall;
    logic [ADDR_W-1:0] pc_inc;
    logic              take_jump;
    logic [ADDR_W-1:0] jump_tgt;

    assign active = (state_q != ST_HALT);
    assign stall  = is_in && !in_valid;
    assign pc_inc = pc_q + ADDR_W'(1);

    // JNC looks at C as left by the previous retired instruction (c_q)
    always_comb begin
        take_jump = is_jmp || (is_jnc && !c_q) || is_call || is_ret;
        jump_tgt  = imm[ADDR_W-1:0];
`ifdef TD4X_CALL_EN
        if (is_ret) begin
            jump_tgt = lr_q;
        end
`endif
    end

    // Next-state logic. RUN and STALL share the same execute path: the
    // STALL state only records that an IN is waiting for its operand.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        out_data_d = out_data_q;
        out_vld_d  = 1'b0;
`ifdef TD4X_CALL_EN
        lr_d       = lr_q;
`endif
        if (active) begin
            if (stall) begin
                state_d = ST_STALL;
            end else if (is_halt) begin
                // PC stays on the HALT address, C is left untouched
                state_d = ST_HALT;
            end else begin
                state_d = ST_RUN;
                c_d     = sum[DATA_W];
                pc_d    = take_jump ? jump_tgt : pc_inc;
                if (wr_a) begin
                    a_d = sum[DATA_W-1:0];
                end
                if (wr_b) begin
                    b_d = sum[DATA_W-1:0];
                end
                if (wr_out) begin
                    out_data_d = sum[DATA_W-1:0];
                    out_vld_d  = 1'b1;
                end
`ifdef TD4X_CALL_EN
                if (is_call) begin
                    lr_d = pc_inc;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
`ifdef TD4X_CALL_EN
            lr_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
`ifdef TD4X_CALL_EN
            lr_q       <= lr_d;
`endif
        end
    end

    assign instr_addr = pc_q;
    assign in_ready   = active && is_in;
    assign out_data   = out_data_q;
    assign out_valid  = out_vld_q;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_td4x_core.sv
module tb_td4x_core;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] instr_addr;
    logic [DATA_W+3:0] instr_data;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;

    logic [7:0] rom [16];
    logic [DATA_W-1:0] exp_q [$];
    int pass_cnt;
    int total_cnt;

    td4x_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    assign instr_data = rom[instr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every output strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            total_cnt = total_cnt + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: out_valid with out_data=%0d, required no output", out_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    $display("FAIL out_data: got %0d, required %0d", out_data, e);
                end else begin
                    pass_cnt = pass_cnt + 1;
                end
            end
        end
    end

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        fill_nop();
        rom[0] = 8'h33; // MOV A,3
        rom[1] = 8'h04; // ADD A,4
        rom[2] = 8'hE5; // JNC 5 (taken: 3+4 has no carry)
        rom[5] = 8'h40; // MOV B,A
        rom[6] = 8'h90; // OUT B
        rom[7] = 8'hA0; // HALT
        exp_q.push_back(4'd7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({instr_addr, out_data, out_valid, halted, in_ready} !== '0)
            $display("FAIL reset_outputs: got pc=%0d out=%0d ov=%0d h=%0d ir=%0d, required all 0",
                     instr_addr, out_data, out_valid, halted, in_ready);
        else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd5) $display("FAIL reset_jnc_taken: pc=%0d, required 5", instr_addr);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || exp_q.size() != 0)
            $display("FAIL reset_done: halted=%0d pending=%0d, required 1 and 0", halted, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_carry_jnc();
        fill_nop();
        rom[0] = 8'h3F; // MOV A,15
        rom[1] = 8'h01; // ADD A,1 -> A=0, C=1
        rom[2] = 8'hE0; // JNC 0 (not taken)
        rom[3] = 8'h40; // MOV B,A
        rom[4] = 8'h90; // OUT B -> 0
        rom[5] = 8'hA0; // HALT
        exp_q.push_back(4'd0);
        reset_dut();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd3) $display("FAIL jnc_not_taken: pc=%0d, required 3", instr_addr);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || exp_q.size() != 0)
            $display("FAIL carry_wrap_done: halted=%0d pending=%0d, required 1 and 0", halted, exp_q.size());
        else pass_cnt++;
        rom[1] = 8'h00; // ADD A,0 -> C=0, JNC taken
        reset_dut();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd0) $display("FAIL jnc_taken: pc=%0d, required 0", instr_addr);
        else pass_cnt++;
    endtask

    task automatic test_in_stall();
        fill_nop();
        rom[0] = 8'h20; // IN A
        rom[1] = 8'h40; // MOV B,A
        rom[2] = 8'h90; // OUT B
        rom[3] = 8'hA0; // HALT
        in_valid = 1'b0;
        in_data  = 4'd2;
        exp_q.push_back(4'd9);
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b1 || instr_addr !== 4'd0)
                $display("FAIL stall_hold[%0d]: in_ready=%0d pc=%0d, required 1 and 0", i, in_ready, instr_addr);
            else pass_cnt++;
            if (i == 3) begin
                in_data  = 4'd9;
                in_valid = 1'b1;
            end
        end
        @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd1 || in_ready !== 1'b0)
            $display("FAIL stall_release: pc=%0d in_ready=%0d, required 1 and 0", instr_addr, in_ready);
        else pass_cnt++;
        in_valid = 1'b0;
        in_data  = 4'd3;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (halted !== 1'b1 || exp_q.size() != 0)
            $display("FAIL in_done: halted=%0d pending=%0d, required 1 and 0", halted, exp_q.size());
        else pass_cnt++;
        // Reset while stalled, with in_valid high on the reset edge: no transfer
        reset_dut();
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (instr_addr !== 4'd0 || in_ready !== 1'b1)
            $display("FAIL rst_in_stall: pc=%0d in_ready=%0d, required 0 and 1", instr_addr, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_out_strobe();
        logic [3:0] ov;
        fill_nop();
        rom[0] = 8'h75; // MOV B,5
        rom[1] = 8'h90; // OUT B
        rom[2] = 8'hBC; // OUT 12
        rom[3] = 8'hA0; // HALT
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd12);
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ov[i] = out_valid;
        end
        total_cnt++;
        if (ov !== 4'b0110) $display("FAIL out_strobe: out_valid seq=%b, required 0110", ov);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL out_pending: %0d left, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        fill_nop();
        reset_dut();
        repeat (15) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd15) $display("FAIL wrap_top: pc=%0d, required 15", instr_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd0 || halted !== 1'b0)
            $display("FAIL wrap_zero: pc=%0d halted=%0d, required 0 and 0", instr_addr, halted);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        bit ok;
        fill_nop();
        rom[6] = 8'hA0;
        reset_dut();
        repeat (6) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd6 || halted !== 1'b0)
            $display("FAIL halt_reach: pc=%0d halted=%0d, required 6 and 0", instr_addr, halted);
        else pass_cnt++;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (instr_addr !== 4'd6 || halted !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL halt_hold: pc=%0d halted=%0d, required 6 and 1 throughout", instr_addr, halted);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (instr_addr !== 4'd0 || halted !== 1'b0)
            $display("FAIL halt_reset: pc=%0d halted=%0d, required 0 and 0", instr_addr, halted);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd1) $display("FAIL halt_restart: pc=%0d, required 1", instr_addr);
        else pass_cnt++;
    endtask

    task automatic test_call();
        logic [3:0] exp1, exp2;
`ifdef TD4X_CALL_EN
        exp1 = 4'd8;
        exp2 = 4'd3;
`else
        exp1 = 4'd3;
        exp2 = 4'd4;
`endif
        fill_nop();
        rom[2] = 8'hC8; // CALL 8
        rom[8] = 8'hD0; // RET
        reset_dut();
        repeat (2) @(negedge clk);
        total_cnt++;
        if (instr_addr !== 4'd2) $display("FAIL call_start: pc=%0d, required 2", instr_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_addr !== exp1) $display("FAIL call_target: pc=%0d, required %0d", instr_addr, exp1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_addr !== exp2) $display("FAIL call_return: pc=%0d, required %0d", instr_addr, exp2);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
        test_reset();
        test_carry_jnc();
        test_in_stall();
        test_out_strobe();
        test_wrap();
        test_halt();
        test_call();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
